// File: rtl/register_file_pkg.sv
// Shared register-file geometry used by decode, writeback and forwarding.
package register_file_pkg;

  localparam int RF_AWIDTH = 5;
  localparam int RF_DWIDTH = 32;
  localparam int RF_NREGS  = 2 ** RF_AWIDTH;

endpackage

// File: rtl/register_file.sv
// 32x32 GPR file: two combinational read ports with same-cycle write bypass, one write port.
// Reads are zero-latency; writes land on the next r_clk rising edge; no backpressure.
module register_file
  import register_file_pkg::*;
#(
  parameter int AWIDTH = RF_AWIDTH,
  parameter int DWIDTH = RF_DWIDTH,
  parameter int NREGS  = RF_NREGS
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_wr_en,
  input  logic [AWIDTH-1:0] r_i_addr_rd,
  input  logic [DWIDTH-1:0] r_i_data_rd,
  input  logic [AWIDTH-1:0] r_i_addr_rs,
  input  logic [AWIDTH-1:0] r_i_addr_rt,
  output logic [DWIDTH-1:0] r_o_data_rs,
  output logic [DWIDTH-1:0] r_o_data_rt
);

  logic [DWIDTH-1:0] regs [NREGS];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (r_wr_en && (r_i_addr_rd != '0)) begin
      regs[r_i_addr_rd] <= r_i_data_rd;
    end
  end

  // Reset forces zero so a bypassed write cannot leak out while the array is held clear.
  function automatic logic [DWIDTH-1:0] read_port(
    input logic              rst_n,
    input logic [AWIDTH-1:0] addr,
    input logic              wr_en,
    input logic [AWIDTH-1:0] wr_addr,
    input logic [DWIDTH-1:0] wr_data,
    input logic [DWIDTH-1:0] stored
  );
    logic [DWIDTH-1:0] dat;
    dat = stored;
    if (!rst_n || (addr == '0)) begin
      dat = '0;
    end else if (wr_en && (addr == wr_addr)) begin
      dat = wr_data;
    end
    return dat;
  endfunction

  assign r_o_data_rs = read_port(r_rst, r_i_addr_rs, r_wr_en, r_i_addr_rd, r_i_data_rd,
                                 regs[r_i_addr_rs]);
  assign r_o_data_rt = read_port(r_rst, r_i_addr_rt, r_wr_en, r_i_addr_rd, r_i_data_rd,
                                 regs[r_i_addr_rt]);

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file: reset, fill, bypass, r0 and reset-mid-cycle cases.
module tb_register_file;
  import register_file_pkg::*;

  logic                 r_clk;
  logic                 r_rst;
  logic                 r_wr_en;
  logic [RF_AWIDTH-1:0] r_i_addr_rd;
  logic [RF_DWIDTH-1:0] r_i_data_rd;
  logic [RF_AWIDTH-1:0] r_i_addr_rs;
  logic [RF_AWIDTH-1:0] r_i_addr_rt;
  logic [RF_DWIDTH-1:0] r_o_data_rs;
  logic [RF_DWIDTH-1:0] r_o_data_rt;

  int errors = 0;
  int checks = 0;

  register_file dut (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .r_wr_en     (r_wr_en),
    .r_i_addr_rd (r_i_addr_rd),
    .r_i_data_rd (r_i_data_rd),
    .r_i_addr_rs (r_i_addr_rs),
    .r_i_addr_rt (r_i_addr_rt),
    .r_o_data_rs (r_o_data_rs),
    .r_o_data_rt (r_o_data_rt)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_both(input int a, input logic [31:0] exp, input string tag);
    r_i_addr_rs = a[RF_AWIDTH-1:0];
    r_i_addr_rt = a[RF_AWIDTH-1:0];
    #1;
    chk($sformatf("%s rs[%0d]", tag, a), r_o_data_rs, exp);
    chk($sformatf("%s rt[%0d]", tag, a), r_o_data_rt, exp);
  endtask

  initial begin
    r_rst       = 1'b0;
    r_wr_en     = 1'b0;
    r_i_addr_rd = '0;
    r_i_data_rd = '0;
    r_i_addr_rs = '0;
    r_i_addr_rt = '0;

    // Reset held for two cycles; every address reads zero.
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    for (int a = 0; a < 32; a++) read_both(a, 32'h0, "reset");

    // A write presented during reset must neither bypass nor land.
    r_wr_en = 1'b1; r_i_addr_rd = 5'd3; r_i_data_rd = 32'h0BAD_0003;
    read_both(3, 32'h0, "rst_bypass");
    @(posedge r_clk);
    @(negedge r_clk);
    r_wr_en = 1'b0;
    r_rst   = 1'b1;
    read_both(3, 32'h0, "rst_nowrite");

    // Fill addresses 0..19 with their own index.
    for (int i = 0; i < 20; i++) begin
      r_wr_en = 1'b1; r_i_addr_rd = i[4:0]; r_i_data_rd = i;
      @(posedge r_clk);
      @(negedge r_clk);
    end
    r_wr_en = 1'b0;
    for (int a = 0; a < 32; a++) read_both(a, (a >= 1 && a < 20) ? a : 0, "fill");

    // Independent addresses on the two ports.
    r_i_addr_rs = 5'd3; r_i_addr_rt = 5'd17;
    #1;
    chk("split rs", r_o_data_rs, 32'd3);
    chk("split rt", r_o_data_rt, 32'd17);

    // Writes to r0 are discarded, including the bypass path.
    @(negedge r_clk);
    r_wr_en = 1'b1; r_i_addr_rd = 5'd0; r_i_data_rd = 32'hDEAD_BEEF;
    read_both(0, 32'h0, "r0_pre");
    @(posedge r_clk);
    @(negedge r_clk);
    r_wr_en = 1'b0;
    read_both(0, 32'h0, "r0_post");

    // Same-cycle write/read on both ports sees new data before and after the edge.
    r_wr_en = 1'b1; r_i_addr_rd = 5'd5; r_i_data_rd = 32'h1234_5678;
    read_both(5, 32'h1234_5678, "byp_pre");
    r_i_addr_rt = 5'd6;
    #1;
    chk("byp other rt", r_o_data_rt, 32'd6);
    @(posedge r_clk);
    @(negedge r_clk);
    r_wr_en = 1'b0;
    read_both(5, 32'h1234_5678, "byp_post");

    // Disabled write leaves entry 7 alone and does not bypass.
    r_wr_en = 1'b0; r_i_addr_rd = 5'd7; r_i_data_rd = 32'hFFFF_FFFF;
    read_both(7, 32'd7, "noen_pre");
    @(posedge r_clk);
    @(negedge r_clk);
    read_both(7, 32'd7, "noen_post");

    // Unknown write address with enable low has no effect.
    r_i_addr_rd = 'x;
    @(posedge r_clk);
    @(negedge r_clk);
    r_i_addr_rd = '0;
    read_both(9, 32'd9, "xaddr 9");
    read_both(19, 32'd19, "xaddr 19");

    // Reset pulled mid-cycle clears outputs immediately.
    r_i_addr_rs = 5'd5; r_i_addr_rt = 5'd12;
    #1;
    chk("pre_rst rs", r_o_data_rs, 32'h1234_5678);
    chk("pre_rst rt", r_o_data_rt, 32'd12);
    #1;
    r_rst = 1'b0;
    #1;
    chk("async rs", r_o_data_rs, 32'h0);
    chk("async rt", r_o_data_rt, 32'h0);

    // Write held across an edge while in reset is lost; first write after release lands.
    r_wr_en = 1'b1; r_i_addr_rd = 5'd9; r_i_data_rd = 32'hAAAA_AAAA;
    @(posedge r_clk);
    @(negedge r_clk);
    r_rst = 1'b1;
    r_i_addr_rd = 5'd10; r_i_data_rd = 32'h0000_CAFE;
    @(posedge r_clk);
    @(negedge r_clk);
    r_wr_en = 1'b0;
    read_both(9, 32'h0, "rst_win");
    read_both(10, 32'h0000_CAFE, "post_rst wr");
    read_both(5, 32'h0, "post_rst 5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: bench did not finish, want finish before 20000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
